// File: rtl/csr_pkg.sv
// Shared definitions for the entry-address CSR bank.
//  - CSR index constants inside the bank
//  - ENTRY_ALIGN_LSB: low bits that are hardwired to zero in every entry address
//  - csr_wr_t: one buffered speculative write {sel, data, mask} at the default widths
package csr_pkg;
  localparam int CSR_EENTRY      = 0;
  localparam int CSR_TLBRENTRY   = 1;
  localparam int CSR_MERRENTRY   = 2;
  localparam int ENTRY_ALIGN_LSB = 6;

  localparam int CSR_NUM_REGS = 3;
  localparam int CSR_DATA_W   = 32;
  localparam int CSR_SEL_W    = $clog2(CSR_NUM_REGS);

  typedef struct packed {
    logic [CSR_SEL_W-1:0]  sel;
    logic [CSR_DATA_W-1:0] data;
    logic [CSR_DATA_W-1:0] mask;
  } csr_wr_t;
endpackage

// File: rtl/csr_entry_bank_if.sv
// Write-side handshake between the CSR execute unit (master) and the entry bank (slave).
//  valid/ready : a write transfers when both are high
//  sel         : target register index
//  data, mask  : write value and field mask (all-ones for CSRWR, rj for CSRXCHG)
interface csr_entry_bank_if #(
  parameter int SEL_W  = 2,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] mask;

  modport master (output valid, sel, data, mask, input ready);
  modport slave  (input valid, sel, data, mask, output ready);
endinterface

// File: rtl/csr_pend_fifo.sv
// In-order pending-write buffer.
//  push/pop/clear : enqueue at tail, dequeue head, drop everything (clear wins)
//  full, count    : occupancy; full/empty come from count, not pointer equality
//  head           : oldest entry
//  ents/vld       : every slot presented oldest-first, vld[i] = slot i holds a write
module csr_pend_fifo
  import csr_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = csr_wr_t,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  T              din,
  output logic          full,
  output logic [CW-1:0] count,
  output T              head,
  output T              ents [DEPTH],
  output logic [DEPTH-1:0] vld
);
  T              mem [DEPTH];
  logic [PW-1:0] wptr, rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // storage carries no reset; occupancy alone decides what is live
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= din;
  end

  assign full = (count == CW'(DEPTH));
  assign head = mem[rptr];

  // rotate so slot 0 is always the oldest write; pointer add wraps modulo DEPTH
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ents[i] = mem[rptr + PW'(i)];
      vld[i]  = (CW'(i) < count);
    end
  end
endmodule

// File: rtl/csr_entry_bank.sv
// Bank of exception / TLB-refill entry-address CSRs with a speculative write buffer.
//  clk, rst_n   : clock, async active-low reset
//  wr           : write handshake (slave side) from the CSR execute unit
//  commit_valid : oldest pending write retires
//  flush        : drop every pending write (a same-cycle commit still lands first)
//  rd_sel/rd_data : speculative read = committed value with pending writes folded in
//  entry_out    : committed values, reg i at [i*DATA_W +: DATA_W]
//  pend_count   : pending writes held
//  commit_err   : one-cycle pulse after a commit request hits an empty buffer
module csr_entry_bank
  import csr_pkg::*;
#(
  parameter int  NUM_REGS   = 3,
  parameter int  DATA_W     = 32,
  parameter int  ALIGN_LSB  = ENTRY_ALIGN_LSB,
  parameter int  PEND_DEPTH = 4,
  localparam int SEL_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int CNT_W      = $clog2(PEND_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  csr_entry_bank_if.slave            wr,
  input  logic                       commit_valid,
  input  logic                       flush,
  input  logic [SEL_W-1:0]           rd_sel,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] entry_out,
  output logic [CNT_W-1:0]           pend_count,
  output logic                       commit_err
);
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
  } wr_t;

  // clearing the mask's low bits keeps the alignment bits at zero through every merge
  localparam logic [DATA_W-1:0] KEEP = ~(DATA_W'((64'd1 << ALIGN_LSB) - 64'd1));

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              full, push, do_commit;
  wr_t               din, head;
  wr_t               ents [PEND_DEPTH];
  logic [PEND_DEPTH-1:0] vld;

  // ready looks only at the registered count; a same-cycle commit frees nothing
  assign wr.ready  = !full;
  assign push      = wr.valid && wr.ready && !flush;
  assign do_commit = commit_valid && (pend_count != '0);
  assign din       = '{sel: wr.sel, data: wr.data, mask: wr.mask & KEEP};

  csr_pend_fifo #(.DEPTH(PEND_DEPTH), .T(wr_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (do_commit),
    .clear (flush),
    .din   (din),
    .full  (full),
    .count (pend_count),
    .head  (head),
    .ents  (ents),
    .vld   (vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      commit_err <= 1'b0;
    end else begin
      commit_err <= commit_valid && (pend_count == '0);
      // head with sel >= NUM_REGS matches no register and pops silently
      for (int i = 0; i < NUM_REGS; i++) begin
        if (do_commit && head.sel == SEL_W'(i))
          regs[i] <= (regs[i] & ~head.mask) | (head.data & head.mask);
      end
    end
  end

  always_comb begin
    logic hit;
    rd_data = '0;
    hit     = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data = regs[i];
        hit     = 1'b1;
      end
    end
    // out-of-range index stays 0 even if writes to it are pending
    for (int j = 0; j < PEND_DEPTH; j++) begin
      if (hit && vld[j] && ents[j].sel == rd_sel)
        rd_data = (rd_data & ~ents[j].mask) | (ents[j].data & ents[j].mask);
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign entry_out[g*DATA_W +: DATA_W] = regs[g];
  end
endmodule
